// File: rtl/usb_in_ep.sv
`default_nettype none
// ---------------------------------------------------------------------------------------
// usb_in_ep : buffered USB IN endpoint, packetizer and DATA0/1 toggle.
// Define USB_IN_ZLP_EN to follow full-size transfer ends with a zero-length packet. rev 1.0
// ---------------------------------------------------------------------------------------
module usb_in_ep #(
   parameter int EP      = 0,
   parameter int MAX_PKT = 8,
   parameter int DEPTH   = 64
) (
   input  logic                     clk48,
   input  logic                     rst_n,
   input  logic [7:0]               wr_data,
   input  logic                     wr_valid,
   input  logic                     wr_last,
   output logic                     wr_ready,
   input  logic                     transaction_active,
   input  logic [3:0]               endpoint,
   input  logic                     direction_in,
   input  logic                     setup,
   input  logic                     data_strobe,
   input  logic                     success,
   output logic [7:0]               data_in,
   output logic                     data_in_valid,
   output logic                     data_toggle,
   output logic [1:0]               handshake,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd2} state_t;
   state_t state, state_nxt;

   logic [8:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, wr_ptr_nxt, rd_ptr, rd_base;
   logic [LW-1:0] pkt_len, sent, scan_len;
   logic          zlp_pend, ta_q, setup_q, ready_en;
   logic          ours, in_start, setup_start, ta_fall, wr_fire, commit, rollback, flush;

   assign ours        = transaction_active && (endpoint == 4'(EP));
   assign in_start    = ours && !ta_q && direction_in && !setup && (state == IDLE)
                        && ((level != '0) || zlp_pend);
   assign setup_start = ours && !ta_q && setup;
   assign ta_fall     = ta_q && !transaction_active;
   assign commit      = (state != IDLE) && !transaction_active && success;
   assign rollback    = (state != IDLE) && !transaction_active && !success;
   assign flush       = ta_fall && setup_q && success;
   assign wr_ready    = ready_en && (level != LW'(DEPTH));
   assign wr_fire     = wr_valid && wr_ready;
   assign wr_ptr_nxt  = wr_fire ? wr_ptr + 1'b1 : wr_ptr;

   assign data_in_valid = (state == SEND) && (sent < pkt_len);
   assign data_in       = data_in_valid ? mem[rd_ptr][7:0] : 8'h00;
   assign handshake     = ((level == '0) && !zlp_pend) ? 2'b01 : 2'b00;

`ifdef USB_IN_ZLP_EN
   logic scan_last, pkt_last;
`endif

   // Packet length: stop at the first wr_last byte inside the next MAX_PKT window.
   always_comb begin
      scan_len = (level < LW'(MAX_PKT)) ? level : LW'(MAX_PKT);
`ifdef USB_IN_ZLP_EN
      scan_last = 1'b0;
`endif
      for (int i = MAX_PKT - 1; i >= 0; i--) begin
         if ((LW'(i) < level) && mem[rd_ptr + AW'(i)][8]) begin
            scan_len = LW'(i + 1);
`ifdef USB_IN_ZLP_EN
            scan_last = 1'b1;
`endif
         end
      end
   end

   always_ff @(posedge clk48) begin
      if (wr_fire) mem[wr_ptr] <= {wr_last, wr_data};
   end

   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_start) state_nxt = SEND;
         SEND:    if (!transaction_active) state_nxt = IDLE;
                  else if (sent == pkt_len) state_nxt = DONE;
         DONE:    if (!transaction_active) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         rd_base     <= '0;
         level       <= '0;
         pkt_len     <= '0;
         sent        <= '0;
         data_toggle <= 1'b0;
         ta_q        <= 1'b0;
         setup_q     <= 1'b0;
         ready_en    <= 1'b0;
      end else begin
         ta_q     <= transaction_active;
         ready_en <= 1'b1;
         wr_ptr   <= wr_ptr_nxt;
         if (setup_start)  setup_q <= 1'b1;
         else if (ta_fall) setup_q <= 1'b0;

         if (flush) begin
            // A byte written in the flush cycle is discarded along with the rest.
            rd_ptr      <= wr_ptr_nxt;
            rd_base     <= wr_ptr_nxt;
            level       <= '0;
            data_toggle <= 1'b1;
         end else begin
            level <= level + LW'(wr_fire) - (commit ? sent : '0);
            if (in_start) begin
               pkt_len <= zlp_pend ? '0 : scan_len;
               sent    <= '0;
            end else if ((state == SEND) && transaction_active && data_strobe
                         && (sent < pkt_len)) begin
               rd_ptr <= rd_ptr + 1'b1;
               sent   <= sent + 1'b1;
            end
            if (commit) begin
               rd_base     <= rd_ptr;
               data_toggle <= ~data_toggle;
            end
            if (rollback) rd_ptr <= rd_base;
         end
      end
   end

`ifdef USB_IN_ZLP_EN
   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         zlp_pend <= 1'b0;
         pkt_last <= 1'b0;
      end else begin
         if (in_start) pkt_last <= scan_last;
         if (flush)       zlp_pend <= 1'b0;
         else if (commit) zlp_pend <= (sent == LW'(MAX_PKT)) && pkt_last;
      end
   end
`else
   assign zlp_pend = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_usb_in_ep.sv
`default_nettype none
// tb_usb_in_ep : randomized self-checking bench; expectations come from a byte-queue
// model of the endpoint (pending bytes with transfer-end flags, toggle, zlp flag).
module tb_usb_in_ep;
   localparam int EP      = 0;
   localparam int MAX_PKT = 8;
   localparam int DEPTH   = 64;
`ifdef USB_IN_ZLP_EN
   localparam bit ZLP_EN = 1'b1;
`else
   localparam bit ZLP_EN = 1'b0;
`endif

   logic       clk48, rst_n;
   logic [7:0] wr_data;
   logic       wr_valid, wr_last, wr_ready;
   logic       transaction_active, direction_in, setup, data_strobe, success;
   logic [3:0] endpoint;
   logic [7:0] data_in;
   logic       data_in_valid, data_toggle;
   logic [1:0] handshake;
   logic [6:0] level;

   usb_in_ep #(.EP(EP), .MAX_PKT(MAX_PKT), .DEPTH(DEPTH)) dut (
      .clk48(clk48), .rst_n(rst_n),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_last(wr_last), .wr_ready(wr_ready),
      .transaction_active(transaction_active), .endpoint(endpoint),
      .direction_in(direction_in), .setup(setup), .data_strobe(data_strobe),
      .success(success), .data_in(data_in), .data_in_valid(data_in_valid),
      .data_toggle(data_toggle), .handshake(handshake), .level(level)
   );

   initial clk48 = 1'b0;
   always #10 clk48 = ~clk48;

   typedef struct packed { logic [7:0] d; logic l; } ent_t;
   ent_t q[$];
   bit   m_tog, m_zlp;
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int exp_len();
      int n = 0;
      if (m_zlp) return 0;
      while (n < q.size() && n < MAX_PKT) begin
         n++;
         if (q[n-1].l) break;
      end
      return n;
   endfunction

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"}, data_in_valid, 0);
      chk({tag, "_data"},  data_in, 0);
      chk({tag, "_ready"}, wr_ready, 0);
      chk({tag, "_hs"},    handshake, 2'b01);
      chk({tag, "_level"}, level, 0);
      chk({tag, "_tog"},   data_toggle, 0);
   endtask

   // Entered and left at posedge+1.
   task automatic wr_byte(input logic [7:0] d, input logic l);
      bit room;
      room = (q.size() < DEPTH);
      wr_valid = 1'b1; wr_data = d; wr_last = l;
      @(negedge clk48);
      chk("wr_ready", wr_ready, room);
      chk("wr_level", level, q.size());
      @(posedge clk48); #1;
      wr_valid = 1'b0; wr_last = 1'b0;
      if (room) q.push_back('{d: d, l: l});
   endtask

   task automatic write_xfer(input int n, input bit seq);
      for (int i = 0; i < n; i++) wr_byte(seq ? 8'(i) : 8'($urandom), (i == n - 1));
   endtask

   task automatic do_in(input bit succ, input int limit, input bit wcommit);
      int len, n;
      bit nak, lb, wr_now;
      logic [7:0] wd;
      len = exp_len();
      nak = (q.size() == 0) && !m_zlp;
      n   = (limit < len) ? limit : len;
      transaction_active = 1'b1; endpoint = 4'(EP); direction_in = 1'b1; setup = 1'b0;
      @(negedge clk48);
      chk("handshake", handshake, nak ? 2'b01 : 2'b00);
      @(posedge clk48); #1;
      if (nak) begin
         data_strobe = 1'b1;
         repeat (3) begin
            @(negedge clk48);
            chk("nak_valid", data_in_valid, 0);
            @(posedge clk48); #1;
         end
         data_strobe = 1'b0;
      end else begin
         @(negedge clk48);
         chk("pkt_toggle", data_toggle, m_tog);
         chk("pkt_first_valid", data_in_valid, (len > 0));
         @(posedge clk48); #1;
         for (int k = 0; k < n; k++) begin
            data_strobe = 1'b1;
            @(negedge clk48);
            chk("pkt_valid", data_in_valid, 1);
            chk("pkt_data", data_in, q[k].d);
            @(posedge clk48); #1;
         end
         data_strobe = 1'b0;
         @(negedge clk48);
         chk("pkt_end_valid", data_in_valid, (n < len));
         @(posedge clk48); #1;
      end
      transaction_active = 1'b0; success = succ;
      wr_now = wcommit && (q.size() < DEPTH);
      wd = 8'($urandom);
      if (wr_now) begin wr_valid = 1'b1; wr_data = wd; wr_last = 1'b1; end
      @(posedge clk48); #1;
      success = 1'b0; wr_valid = 1'b0; wr_last = 1'b0;
      if (!nak && succ) begin
         lb = 1'b0;
         for (int k = 0; k < n; k++) begin lb = q[0].l; void'(q.pop_front()); end
         m_tog = !m_tog;
         m_zlp = ZLP_EN && (n == MAX_PKT) && lb;
      end
      if (wr_now) q.push_back('{d: wd, l: 1'b1});
      @(negedge clk48);
      chk("post_level", level, q.size());
      chk("post_toggle", data_toggle, m_tog);
      chk("post_valid", data_in_valid, 0);
      @(posedge clk48); #1;
   endtask

   task automatic do_other(input bit use_out);
      transaction_active = 1'b1; setup = 1'b0;
      endpoint     = use_out ? 4'(EP) : 4'($urandom_range(1, 15));
      direction_in = !use_out;
      data_strobe  = 1'b1;
      repeat (3) begin
         @(posedge clk48); #1;
         @(negedge clk48);
         chk("other_valid", data_in_valid, 0);
      end
      @(posedge clk48); #1;
      data_strobe = 1'b0; transaction_active = 1'b0; success = 1'b1;
      @(posedge clk48); #1;
      success = 1'b0;
      @(negedge clk48);
      chk("other_level", level, q.size());
      chk("other_toggle", data_toggle, m_tog);
      @(posedge clk48); #1;
   endtask

   task automatic do_setup(input bit succ);
      transaction_active = 1'b1; endpoint = 4'(EP); setup = 1'b1; direction_in = 1'b0;
      repeat (2) @(posedge clk48);
      #1;
      @(negedge clk48);
      chk("setup_valid", data_in_valid, 0);
      @(posedge clk48); #1;
      transaction_active = 1'b0; setup = 1'b0; success = succ;
      @(posedge clk48); #1;
      success = 1'b0;
      if (succ) begin q.delete(); m_tog = 1'b1; m_zlp = 1'b0; end
      @(negedge clk48);
      chk("setup_level", level, q.size());
      chk("setup_toggle", data_toggle, m_tog);
      chk("setup_hs", handshake, (q.size() == 0 && !m_zlp) ? 2'b01 : 2'b00);
      @(posedge clk48); #1;
   endtask

   initial begin
      int room, nb;
      rst_n = 1'b0; wr_data = 8'h00; wr_valid = 1'b0; wr_last = 1'b0;
      transaction_active = 1'b0; endpoint = 4'h0; direction_in = 1'b0; setup = 1'b0;
      data_strobe = 1'b0; success = 1'b0;
      m_tog = 1'b0; m_zlp = 1'b0;
      #35;
      chk_reset_outputs("reset");
      @(posedge clk48); #1;
      rst_n = 1'b1;
      @(posedge clk48); #1;
      @(negedge clk48);
      chk("ready_after_reset", wr_ready, 1);
      @(posedge clk48); #1;

      // Descriptor-like 4-byte transfer.
      wr_byte(8'h12, 1'b0); wr_byte(8'h01, 1'b0); wr_byte(8'h00, 1'b0); wr_byte(8'h02, 1'b1);
      do_in(1'b1, 99, 1'b0);
      @(negedge clk48);
      chk("first_pkt_toggle", data_toggle, 1);
      chk("first_pkt_level", level, 0);
      @(posedge clk48); #1;

      do_in(1'b1, 99, 1'b0);                      // empty -> NAK

      write_xfer(18, 1'b1);                       // 8, 8, 2
      repeat (3) do_in(1'b1, 99, 1'b0);

      write_xfer(8, 1'b0);                        // failed then retried
      do_in(1'b0, 99, 1'b0);
      do_in(1'b1, 99, 1'b0);

      write_xfer(8, 1'b0);                        // full packet ending on wr_last
      do_in(1'b1, 99, 1'b0);
      do_in(1'b1, 99, 1'b0);

      write_xfer(5, 1'b0);
      do_other(1'b0);
      do_other(1'b1);
      do_setup(1'b0);
      do_setup(1'b1);

      write_xfer(DEPTH, 1'b0);                    // fill to the brim
      wr_byte(8'hAA, 1'b1);
      repeat (DEPTH / MAX_PKT) do_in(1'b1, 99, 1'b1);
      while (q.size() > 0 || m_zlp) do_in(1'b1, 99, 1'b0);

      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 4))
            0, 1: begin
               room = DEPTH - q.size();
               nb   = $urandom_range(1, 12);
               if (nb > room) nb = room;
               if (nb > 0) write_xfer(nb, 1'b0);
            end
            2, 3: do_in($urandom_range(0, 3) != 0,
                        ($urandom_range(0, 3) == 0) ? $urandom_range(0, MAX_PKT) : 99,
                        $urandom_range(0, 1) == 1);
            default: do_other($urandom_range(0, 1) == 1);
         endcase
      end
      while (q.size() > 0 || m_zlp) do_in(1'b1, 99, 1'b0);

      // Reset in the middle of a packet.
      write_xfer(8, 1'b0);
      transaction_active = 1'b1; endpoint = 4'(EP); direction_in = 1'b1;
      @(posedge clk48); #1;
      data_strobe = 1'b1;
      repeat (3) @(posedge clk48);
      #1;
      data_strobe = 1'b0;
      @(negedge clk48);
      chk("midpkt_data", data_in, q[3].d);
      #2;
      rst_n = 1'b0; transaction_active = 1'b0;
      #1;
      chk_reset_outputs("midpkt_reset");
      q.delete(); m_tog = 1'b0; m_zlp = 1'b0;
      @(posedge clk48); #1;
      rst_n = 1'b1;
      @(posedge clk48); #1;
      do_in(1'b1, 99, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
